// File: rtl/enc_dec_pkg.sv
// -----------------------------------------------------------------------------
// enc_dec_pkg
//   Shared types, constants and helpers for the extended-Hamming encode/decode
//   core (enc_dec_core and its combinational datapath enc_dec_hamming).
//
//   Contents:
//     op_e      operation selected by ctrl[1:0]
//     width_e   codeword width selected by codeword_width[1:0]
//     state_e   core FSM states
//     N/K localparams per width, DATA_WIDTH_MAX, error-code constants
//     cw_mask   mask of the N valid codeword bits for a width
//     data_idx  payload bit index carried at a (non-parity) Hamming position
//     index_xor XOR of the indices of all set bits 1..31 (Hamming syndrome)
// -----------------------------------------------------------------------------
package enc_dec_pkg;

    localparam int DATA_WIDTH_MAX = 26;
    localparam int CW_WIDTH       = 32;

    localparam int N_W8  = 8;
    localparam int K_W8  = 4;
    localparam int N_W16 = 16;
    localparam int K_W16 = 11;
    localparam int N_W32 = 32;
    localparam int K_W32 = 26;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CORR    = 2'd1;
    localparam logic [1:0] ERR_UNCORR  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ENCODE  = 2'b00,
        DECODE  = 2'b01,
        FULL    = 2'b10,
        ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10
    } width_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ENC  = 2'b01,
        DEC  = 2'b10
    } state_e;

    // Bits of the 32-bit codeword that belong to an N-bit codeword.
    function automatic logic [31:0] cw_mask(input width_e w);
        case (w)
            W8:      return 32'h0000_00FF;
            W16:     return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Payload bit carried at Hamming position pos (pos not a power of two).
    // Positions 1..pos contain floor(log2(pos))+1 parity slots, so the payload
    // index does not depend on N: the narrow widths simply stop earlier.
    function automatic int data_idx(input int pos);
        int lg;
        lg = 0;
        for (int b = 0; b < 5; b++) begin
            if (pos >= (2 << b)) begin
                lg = b + 1;
            end
        end
        return pos - lg - 2;
    endfunction

    // XOR of the positions of every set bit at index >= 1.
    function automatic logic [4:0] index_xor(input logic [31:0] v);
        logic [4:0] s;
        s = '0;
        for (int j = 1; j < 32; j++) begin
            if (v[j]) begin
                s = s ^ 5'(j);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/enc_dec_hamming.sv
// -----------------------------------------------------------------------------
// enc_dec_hamming
//   Purely combinational extended-Hamming datapath for a 32-bit codeword
//   container, narrowed to N = 8/16/32 by width_sel. Both the encoder and the
//   decoder are evaluated every cycle; the core picks whichever it needs.
//
//   Ports:
//     width_sel  in  2   codeword width (W8/W16/W32; 11 never presented)
//     data_in    in  26  payload to encode (bits >= K ignored)
//     cw_in      in  32  received codeword to decode (bits >= N ignored)
//     cw_out     out 32  encoded codeword, zero above N
//     data_out   out 26  corrected payload, zero above K
//     err        out 2   0 clean, 1 corrected, 2 uncorrectable
// -----------------------------------------------------------------------------
module enc_dec_hamming
    import enc_dec_pkg::*;
(
    input  logic [1:0]                width_sel,
    input  logic [DATA_WIDTH_MAX-1:0] data_in,
    input  logic [CW_WIDTH-1:0]       cw_in,
    output logic [CW_WIDTH-1:0]       cw_out,
    output logic [DATA_WIDTH_MAX-1:0] data_out,
    output logic [1:0]                err
);

    logic [31:0] mask;
    logic [31:0] scat;
    logic [31:0] cw_enc;
    logic [31:0] cw_masked;
    logic [31:0] cw_fixed;
    logic [4:0]  enc_syn;
    logic [4:0]  dec_syn;
    logic        dec_par;
    logic        unused_parity;

    assign mask = cw_mask(width_e'(width_sel));

    // Scatter payload onto non-parity positions and gather it back after
    // correction. The mask drops positions >= N, which also drops payload
    // bits >= K.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pos
            if (gi == 0 || (gi & (gi - 1)) == 0) begin : g_par
                assign scat[gi] = 1'b0;
            end else begin : g_data
                assign scat[gi]                = mask[gi] & data_in[data_idx(gi)];
                assign data_out[data_idx(gi)]  = cw_fixed[gi];
            end
        end
    endgenerate

    // Parity bit 2^k equals bit k of the XOR of all set data positions, which
    // makes the syndrome of the finished codeword zero.
    always_comb begin
        enc_syn    = index_xor(scat);
        cw_enc     = scat;
        cw_enc[1]  = enc_syn[0];
        cw_enc[2]  = enc_syn[1];
        cw_enc[4]  = enc_syn[2];
        cw_enc[8]  = enc_syn[3];
        cw_enc[16] = enc_syn[4];
        cw_enc[0]  = ^cw_enc[31:1];
    end

    assign cw_out = cw_enc;

    // Odd overall parity means a single flip at position dec_syn (0 => the
    // overall parity bit itself). Even parity with a non-zero syndrome is a
    // double error, left uncorrected.
    always_comb begin
        cw_masked = cw_in & mask;
        dec_syn   = index_xor(cw_masked);
        dec_par   = ^cw_masked;
        cw_fixed  = cw_masked;
        err       = ERR_NONE;
        if (dec_par) begin
            cw_fixed[dec_syn] = ~cw_masked[dec_syn];
            err               = ERR_CORR;
        end else if (dec_syn != 5'd0) begin
            err = ERR_UNCORR;
        end
    end

    // Parity positions carry no payload after correction.
    assign unused_parity = ^{cw_fixed[0], cw_fixed[1], cw_fixed[2],
                             cw_fixed[4], cw_fixed[8], cw_fixed[16]};

endmodule

// File: rtl/enc_dec_core.sv
// -----------------------------------------------------------------------------
// enc_dec_core
//   Runs one extended-Hamming operation per start pulse: encode, decode, or
//   full channel (encode, XOR noise, decode). Inputs are snapshotted when the
//   operation is accepted, so register writes mid-operation have no effect.
//
//   Latency from the edge that samples start: illegal 1, encode/decode 2,
//   full channel 3 cycles. start while busy is dropped.
//
//   Ports:
//     clk             in   1          clock
//     rstn            in   1          asynchronous active-low reset
//     start           in   1          operation request pulse
//     ctrl            in   AMBA_WORD  [1:0] op; [31] clears counters (option)
//     data_in         in   AMBA_WORD  payload or received codeword
//     codeword_width  in   AMBA_WORD  [1:0] width select
//     noise           in   AMBA_WORD  full-channel XOR mask (bits >= N ignored)
//     data_out        out  AMBA_WORD  codeword or payload, zero-extended
//     operation_done  out  1          single-cycle completion pulse
//     num_of_errors   out  2          0 none, 1 corrected, 2 uncorrectable,
//                                     3 illegal configuration
//     busy            out  1          operation in progress
//     corr_cnt        out  16         corrected-op count   (ENC_DEC_ERR_CNT_EN)
//     uncorr_cnt      out  16         uncorrectable count  (ENC_DEC_ERR_CNT_EN)
//
//   Build option: define ENC_DEC_ERR_CNT_EN to add the saturating error
//   counters and their ports.
// -----------------------------------------------------------------------------
module enc_dec_core
    import enc_dec_pkg::*;
#(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] ctrl,
    input  logic [AMBA_WORD-1:0] data_in,
    input  logic [AMBA_WORD-1:0] codeword_width,
    input  logic [AMBA_WORD-1:0] noise,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors,
`ifdef ENC_DEC_ERR_CNT_EN
    output logic                 busy,
    output logic [15:0]          corr_cnt,
    output logic [15:0]          uncorr_cnt
`else
    output logic                 busy
`endif
);

    state_e                    state_reg;
    op_e                       op_reg;
    logic [1:0]                width_reg;
    logic [DATA_WIDTH_MAX-1:0] data_reg;
    logic [CW_WIDTH-1:0]       noise_reg;
    logic [CW_WIDTH-1:0]       cw_reg;
    logic [AMBA_WORD-1:0]      data_out_reg;
    logic [1:0]                num_of_errors_reg;
    logic                      operation_done_reg;

    logic [CW_WIDTH-1:0]       enc_cw;
    logic [DATA_WIDTH_MAX-1:0] dec_data;
    logic [1:0]                dec_err;

    op_e                       start_op;
    logic                      start_illegal;
    logic                      unused_inputs;

    assign start_op      = op_e'(ctrl[1:0]);
    assign start_illegal = (ctrl[1:0] == 2'b11) || (codeword_width[1:0] == 2'b11);

    // Only the low bits of the wide registers carry meaning.
    assign unused_inputs = ^{ctrl, data_in, codeword_width, noise};

    // Shared datapath: encoder reads the payload snapshot, decoder reads
    // cw_reg (received word, or noisy codeword in full-channel mode).
    enc_dec_hamming u_hamming (
        .width_sel (width_reg),
        .data_in   (data_reg),
        .cw_in     (cw_reg),
        .cw_out    (enc_cw),
        .data_out  (dec_data),
        .err       (dec_err)
    );

`ifdef ENC_DEC_ERR_CNT_EN
    logic [15:0] corr_cnt_reg;
    logic [15:0] uncorr_cnt_reg;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg          <= IDLE;
            op_reg             <= ENCODE;
            width_reg          <= 2'b00;
            data_reg           <= '0;
            noise_reg          <= '0;
            cw_reg             <= '0;
            data_out_reg       <= '0;
            num_of_errors_reg  <= ERR_NONE;
            operation_done_reg <= 1'b0;
`ifdef ENC_DEC_ERR_CNT_EN
            corr_cnt_reg       <= '0;
            uncorr_cnt_reg     <= '0;
`endif
        end else begin
            operation_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
`ifdef ENC_DEC_ERR_CNT_EN
                        if (ctrl[31]) begin
                            corr_cnt_reg   <= '0;
                            uncorr_cnt_reg <= '0;
                        end
`endif
                        if (start_illegal) begin
                            // Finish straight from IDLE without computing.
                            data_out_reg       <= '0;
                            num_of_errors_reg  <= ERR_ILLEGAL;
                            operation_done_reg <= 1'b1;
                        end else begin
                            op_reg    <= start_op;
                            width_reg <= codeword_width[1:0];
                            data_reg  <= data_in[DATA_WIDTH_MAX-1:0];
                            noise_reg <= noise[CW_WIDTH-1:0];
                            cw_reg    <= data_in[CW_WIDTH-1:0];
                            state_reg <= (start_op == DECODE) ? DEC : ENC;
                        end
                    end
                end

                ENC: begin
                    if (op_reg == FULL) begin
                        cw_reg    <= enc_cw ^ (noise_reg & cw_mask(width_e'(width_reg)));
                        state_reg <= DEC;
                    end else begin
                        data_out_reg       <= AMBA_WORD'(enc_cw);
                        num_of_errors_reg  <= ERR_NONE;
                        operation_done_reg <= 1'b1;
                        state_reg          <= IDLE;
                    end
                end

                DEC: begin
                    data_out_reg       <= AMBA_WORD'(dec_data);
                    num_of_errors_reg  <= dec_err;
                    operation_done_reg <= 1'b1;
                    state_reg          <= IDLE;
`ifdef ENC_DEC_ERR_CNT_EN
                    if (dec_err == ERR_CORR && corr_cnt_reg != 16'hFFFF) begin
                        corr_cnt_reg <= corr_cnt_reg + 16'd1;
                    end
                    if (dec_err == ERR_UNCORR && uncorr_cnt_reg != 16'hFFFF) begin
                        uncorr_cnt_reg <= uncorr_cnt_reg + 16'd1;
                    end
`endif
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_out       = data_out_reg;
    assign num_of_errors  = num_of_errors_reg;
    assign operation_done = operation_done_reg;
    assign busy           = (state_reg != IDLE);

`ifdef ENC_DEC_ERR_CNT_EN
    assign corr_cnt   = corr_cnt_reg;
    assign uncorr_cnt = uncorr_cnt_reg;
`endif

endmodule
